// File: rtl/spi_frame_shifter.sv
// spi_frame_shifter: SPI mode-0 master datapath, one DATA_W-bit word per cs-low window
module spi_frame_shifter #(
  parameter int DATA_W = 16,
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              miso,
  output logic              sclk,
  output logic              mosi,
  output logic              sent,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy
);
  localparam int BW = $clog2(DATA_W);
  localparam int DW = $clog2(CLK_DIV + 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE, WAIT_CS} state_t;
  state_t state;
  // the MSB goes straight to mosi at frame start, so only the remaining bits are queued
  logic [DATA_W-2:0] tx_shift;
  logic [DATA_W-1:0] rx_shift;
  logic [BW-1:0] bit_cnt;
  logic [DW-1:0] div_cnt;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      sclk <= 1'b0;
      mosi <= 1'b0;
      sent <= 1'b0;
      rx_valid <= 1'b0;
      busy <= 1'b0;
      rx_data <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
      bit_cnt <= '0;
      div_cnt <= '0;
    end else begin
      sent <= 1'b0;
      rx_valid <= 1'b0;
      case (state)
        IDLE: begin
          sclk <= 1'b0;
          if (!cs) begin
            tx_shift <= tx_data[DATA_W-2:0];
            mosi <= tx_data[DATA_W-1];
            bit_cnt <= '0;
            div_cnt <= '0;
            busy <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (cs) begin
            state <= IDLE;
            sclk <= 1'b0;
            busy <= 1'b0;
          end else if (div_cnt != DIV_LAST) begin
            div_cnt <= div_cnt + DW'(1);
          end else begin
            div_cnt <= '0;
            sclk <= !sclk;
            if (!sclk) begin
              rx_shift <= {rx_shift[DATA_W-2:0], miso};
            end else if (bit_cnt != BIT_LAST) begin
              bit_cnt <= bit_cnt + BW'(1);
              mosi <= tx_shift[DATA_W-2];
              tx_shift <= tx_shift << 1;
            end else begin
              state <= DONE;
              sent <= 1'b1;
              rx_valid <= 1'b1;
              rx_data <= rx_shift;
            end
          end
        end
        DONE: begin
          busy <= 1'b0;
          state <= WAIT_CS;
        end
        WAIT_CS: begin
          sclk <= 1'b0;
          if (cs) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_frame_shifter.sv
// tb_spi_frame_shifter: vector table plus random frames against a frame-level reference model
module tb_spi_frame_shifter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic cs_a = 1'b1;
  logic [15:0] tx_a = '0;
  logic miso_a = 1'b0;
  logic sclk_a, mosi_a, sent_a, rx_valid_a, busy_a;
  logic [15:0] rx_data_a;
  logic cs_b = 1'b1;
  logic [7:0] tx_b = '0;
  logic miso_b = 1'b0;
  logic sclk_b, mosi_b, sent_b, rx_valid_b, busy_b;
  logic [7:0] rx_data_b;
  spi_frame_shifter dut_a (
    .clk(clk), .rst_n(rst_n), .cs(cs_a), .tx_data(tx_a), .miso(miso_a), .sclk(sclk_a),
    .mosi(mosi_a), .sent(sent_a), .rx_data(rx_data_a), .rx_valid(rx_valid_a), .busy(busy_a)
  );
  spi_frame_shifter #(.DATA_W(8), .CLK_DIV(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .cs(cs_b), .tx_data(tx_b), .miso(miso_b), .sclk(sclk_b),
    .mosi(mosi_b), .sent(sent_b), .rx_data(rx_data_b), .rx_valid(rx_valid_b), .busy(busy_b)
  );
  int errors = 0;
  int checks = 0;
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  typedef struct {
    logic [15:0] tx;
    logic [15:0] mw;
    int abort_at;
    int rst_at;
    bit hold_low;
    bit exp_sent;
    logic [15:0] exp_rx;
  } vec_t;
  vec_t vecs[7];
  // one frame on dut_a; sample n is taken just after edge E0+n
  task automatic run_a(input vec_t v);
    int rises = 0;
    int sent_cnt = 0;
    int rv_cnt = 0;
    int sent_n = -1;
    int bad_period = 0;
    logic [15:0] got = '0;
    logic prev = 1'b0;
    @(negedge clk);
    tx_a = v.tx;
    cs_a = 1'b0;
    miso_a = v.mw[15];
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (n == 0) check("busy_start", busy_a, 1);
      tx_a = 16'($urandom);
      if (sclk_a && !prev) begin
        rises++;
        got = {got[14:0], mosi_a};
        if (n != (2 * rises - 1) * 4) bad_period++;
      end
      prev = sclk_a;
      if (rx_valid_a) rv_cnt++;
      if (sent_a) begin
        sent_cnt++;
        sent_n = n;
        if (!v.hold_low) cs_a = 1'b1;
      end
      miso_a = rises < 16 ? v.mw[15 - rises] : 1'b0;
      if (v.abort_at > 0 && n == v.abort_at - 1) cs_a = 1'b1;
      if (v.abort_at > 0 && n == v.abort_at + 1) check("abort_idle", {busy_a, sclk_a}, 0);
      if (v.rst_at > 0 && n == v.rst_at - 1) rst_n = 1'b0;
      if (v.rst_at > 0 && n == v.rst_at) begin
        check("midrst_outs", {sclk_a, mosi_a, sent_a, rx_valid_a, busy_a}, 0);
        check("midrst_rx", rx_data_a, 0);
        rst_n = 1'b1;
        cs_a = 1'b1;
      end
    end
    check("sent_count", sent_cnt, v.exp_sent);
    check("rx_valid_count", rv_cnt, v.exp_sent);
    if (v.exp_sent) begin
      check("sent_time", sent_n, 128);
      check("rise_count", rises, 16);
      check("sclk_period", bad_period, 0);
      check("mosi_seq", got, v.tx);
    end
    check("rx_data", rx_data_a, v.exp_rx);
    cs_a = 1'b1;
    repeat (3) @(negedge clk);
  endtask
  initial begin
    logic [15:0] last_rx;
    vec_t r;
    int rises;
    int sent_cnt;
    int sent_n;
    int bad_period;
    logic [7:0] got;
    logic [7:0] mw;
    logic prev;
    vecs[0] = '{16'hA5C3, 16'h3C5A, 0, 0, 1'b0, 1'b1, 16'h3C5A};
    vecs[1] = '{16'hFFFF, 16'h0000, 0, 0, 1'b1, 1'b1, 16'h0000};
    vecs[2] = '{16'h1234, 16'hABCD, 40, 0, 1'b0, 1'b0, 16'h0000};
    vecs[3] = '{16'h0F0F, 16'hF00F, 0, 0, 1'b0, 1'b1, 16'hF00F};
    vecs[4] = '{16'h5555, 16'h1234, 40, 0, 1'b0, 1'b0, 16'hF00F};
    vecs[5] = '{16'h8001, 16'h7FFE, 0, 60, 1'b0, 1'b0, 16'h0000};
    vecs[6] = '{16'hC3A5, 16'h8001, 0, 0, 1'b0, 1'b1, 16'h8001};
    repeat (3) @(negedge clk);
    check("reset_outs_a", {sclk_a, mosi_a, sent_a, rx_valid_a, busy_a}, 0);
    check("reset_rx_a", rx_data_a, 0);
    check("reset_outs_b", {sclk_b, mosi_b, sent_b, rx_valid_b, busy_b}, 0);
    check("reset_rx_b", rx_data_b, 0);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 7; i++) run_a(vecs[i]);
    last_rx = vecs[6].exp_rx;
    for (int i = 0; i < 8; i++) begin
      r.tx = 16'($urandom);
      r.mw = 16'($urandom);
      r.abort_at = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 120)) : 0;
      r.rst_at = 0;
      r.hold_low = 1'(i % 3 == 0);
      r.exp_sent = (r.abort_at == 0);
      if (r.exp_sent) last_rx = r.mw;
      r.exp_rx = last_rx;
      run_a(r);
    end
    rises = 0;
    sent_cnt = 0;
    sent_n = -1;
    bad_period = 0;
    got = '0;
    prev = 1'b0;
    mw = 8'h5A;
    @(negedge clk);
    tx_b = 8'h81;
    cs_b = 1'b0;
    miso_b = mw[7];
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      tx_b = 8'($urandom);
      if (sclk_b && !prev) begin
        rises++;
        got = {got[6:0], mosi_b};
        if (n != 2 * rises - 1) bad_period++;
      end
      prev = sclk_b;
      if (sent_b) begin
        sent_cnt++;
        sent_n = n;
        cs_b = 1'b1;
      end
      miso_b = rises < 8 ? mw[7 - rises] : 1'b0;
    end
    check("b_sent_count", sent_cnt, 1);
    check("b_sent_time", sent_n, 16);
    check("b_rise_count", rises, 8);
    check("b_sclk_period", bad_period, 0);
    check("b_mosi_seq", got, 8'h81);
    check("b_rx_data", rx_data_b, 8'h5A);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
